// File: rtl/uvmt_apb_st_fanout_pkg.sv
// Shared types and helpers for the APB fan-out bridge.
package uvmt_apb_st_fanout_pkg;

  // Transfer FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } fanout_state_t;

  // Width of the saturating error-response counter
  localparam int ERR_CNT_W = 16;

  // Slave index width: at least one bit so a single-slave bridge still
  // has an address bit that selects the (unmapped) second window.
  function automatic int calc_idx_w(input int num_slv);
    return (num_slv <= 1) ? 1 : $clog2(num_slv);
  endfunction

endpackage

// File: rtl/uvmt_apb_st_fanout_dec.sv
// Address decoder: maps paddr to a slave index and flags unmapped addresses.
module uvmt_apb_st_fanout_dec
  import uvmt_apb_st_fanout_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLV    = 4,
  parameter int WIN_BITS   = 12,
  localparam int IDX_W     = calc_idx_w(NUM_SLV)
) (
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  output logic [IDX_W-1:0]      o_idx,
  output logic                  o_dec_err
);

  localparam int HI_LSB = WIN_BITS + IDX_W;

  logic [IDX_W-1:0] w_idx;
  logic             w_hi_set;

  assign w_idx = i_paddr[WIN_BITS +: IDX_W];

  // Any address bit above the index field lands outside every window.
  generate
    if (HI_LSB < ADDR_WIDTH) begin : g_hi
      assign w_hi_set = |i_paddr[ADDR_WIDTH-1:HI_LSB];
    end else begin : g_no_hi
      assign w_hi_set = 1'b0;
    end
  endgenerate

  assign o_idx     = w_idx;
  assign o_dec_err = w_hi_set || ({{(32-IDX_W){1'b0}}, w_idx} >= 32'(NUM_SLV));

endmodule

// File: rtl/uvmt_apb_st_fanout_bridge.sv
// APB fan-out bridge: one upstream completer port to NUM_SLV downstream
// requester ports, with decode-error, timeout and a saturating error count.
module uvmt_apb_st_fanout_bridge
  import uvmt_apb_st_fanout_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLV        = 4,
  parameter int WIN_BITS       = 12,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_WIDTH      = ERR_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_WIDTH-1:0]         m_paddr,
  input  logic                          m_psel,
  input  logic                          m_penable,
  input  logic                          m_pwrite,
  input  logic [DATA_WIDTH-1:0]         m_pwdata,
  output logic                          m_pready,
  output logic                          m_pslverr,
  output logic [DATA_WIDTH-1:0]         m_prdata,
  output logic [ADDR_WIDTH-1:0]         s_paddr,
  output logic                          s_pwrite,
  output logic [DATA_WIDTH-1:0]         s_pwdata,
  output logic [NUM_SLV-1:0]            s_psel,
  output logic                          s_penable,
  input  logic [NUM_SLV-1:0]            s_pready,
  input  logic [NUM_SLV-1:0]            s_pslverr,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] s_prdata,
  output logic [ERR_WIDTH-1:0]          err_count
);

  localparam int IDX_W = calc_idx_w(NUM_SLV);
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  fanout_state_t r_state, w_state_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [TMO_W-1:0]      r_tmo, w_tmo_next;
  logic [ADDR_WIDTH-1:0] r_s_paddr, w_s_paddr_next;
  logic                  r_s_pwrite, w_s_pwrite_next;
  logic [DATA_WIDTH-1:0] r_s_pwdata, w_s_pwdata_next;
  logic [NUM_SLV-1:0]    r_s_psel, w_s_psel_next;
  logic                  r_s_penable, w_s_penable_next;
  logic                  r_m_pready, w_m_pready_next;
  logic                  r_m_pslverr, w_m_pslverr_next;
  logic [DATA_WIDTH-1:0] r_m_prdata, w_m_prdata_next;
  logic [ERR_WIDTH-1:0]  r_err_count, w_err_count_next;
  logic                  w_err_event;

  logic [IDX_W-1:0]      w_dec_idx;
  logic                  w_dec_err;
  logic [NUM_SLV-1:0]    w_dec_onehot;
  logic [DATA_WIDTH-1:0] w_rdata_arr [NUM_SLV];
  logic                  w_sel_pready;
  logic                  w_sel_pslverr;
  logic [DATA_WIDTH-1:0] w_sel_prdata;

  uvmt_apb_st_fanout_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLV    (NUM_SLV),
    .WIN_BITS   (WIN_BITS)
  ) u_dec (
    .i_paddr   (m_paddr),
    .o_idx     (w_dec_idx),
    .o_dec_err (w_dec_err)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign w_dec_onehot[gi] = (w_dec_idx == IDX_W'(gi));
      assign w_rdata_arr[gi]  = s_prdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Pick the response of the slave owning the current transfer; others are ignored.
  always_comb begin
    w_sel_pready  = 1'b0;
    w_sel_pslverr = 1'b0;
    w_sel_prdata  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_pready  = s_pready[i];
        w_sel_pslverr = s_pslverr[i];
        w_sel_prdata  = w_rdata_arr[i];
      end
    end
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    w_state_next     = r_state;
    w_idx_next       = r_idx;
    w_tmo_next       = r_tmo;
    w_s_paddr_next   = r_s_paddr;
    w_s_pwrite_next  = r_s_pwrite;
    w_s_pwdata_next  = r_s_pwdata;
    w_s_psel_next    = r_s_psel;
    w_s_penable_next = r_s_penable;
    w_m_pready_next  = 1'b0;
    w_m_pslverr_next = r_m_pslverr;
    w_m_prdata_next  = r_m_prdata;
    w_err_event      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (m_psel && !m_penable) begin
          w_s_paddr_next  = m_paddr;
          w_s_pwrite_next = m_pwrite;
          w_s_pwdata_next = m_pwdata;
          w_idx_next      = w_dec_idx;
          if (w_dec_err) begin
            w_state_next     = ST_RESP;
            w_m_pready_next  = 1'b1;
            w_m_pslverr_next = 1'b1;
            w_m_prdata_next  = '0;
            w_err_event      = 1'b1;
          end else begin
            w_state_next  = ST_SETUP;
            w_s_psel_next = w_dec_onehot;
          end
        end
      end
      ST_SETUP: begin
        w_state_next     = ST_ACCESS;
        w_s_penable_next = 1'b1;
        w_tmo_next       = '0;
      end
      ST_ACCESS: begin
        if (w_sel_pready) begin
          w_state_next     = ST_RESP;
          w_s_psel_next    = '0;
          w_s_penable_next = 1'b0;
          w_m_pready_next  = 1'b1;
          w_m_pslverr_next = w_sel_pslverr;
          w_m_prdata_next  = r_s_pwrite ? '0 : w_sel_prdata;
          w_err_event      = w_sel_pslverr;
        end else if ((TIMEOUT_CYCLES != 0) && (r_tmo == TMO_LAST)) begin
          w_state_next     = ST_RESP;
          w_s_psel_next    = '0;
          w_s_penable_next = 1'b0;
          w_m_pready_next  = 1'b1;
          w_m_pslverr_next = 1'b1;
          w_m_prdata_next  = '0;
          w_err_event      = 1'b1;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    w_err_count_next = (w_err_event && (r_err_count != '1)) ? r_err_count + 1'b1 : r_err_count;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_s_paddr   <= '0;
      r_s_pwrite  <= 1'b0;
      r_s_pwdata  <= '0;
      r_s_psel    <= '0;
      r_s_penable <= 1'b0;
      r_m_pready  <= 1'b0;
      r_m_pslverr <= 1'b0;
      r_m_prdata  <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_tmo       <= w_tmo_next;
      r_s_paddr   <= w_s_paddr_next;
      r_s_pwrite  <= w_s_pwrite_next;
      r_s_pwdata  <= w_s_pwdata_next;
      r_s_psel    <= w_s_psel_next;
      r_s_penable <= w_s_penable_next;
      r_m_pready  <= w_m_pready_next;
      r_m_pslverr <= w_m_pslverr_next;
      r_m_prdata  <= w_m_prdata_next;
      r_err_count <= w_err_count_next;
    end
  end

  assign m_pready  = r_m_pready;
  assign m_pslverr = r_m_pslverr;
  assign m_prdata  = r_m_prdata;
  assign s_paddr   = r_s_paddr;
  assign s_pwrite  = r_s_pwrite;
  assign s_pwdata  = r_s_pwdata;
  assign s_psel    = r_s_psel;
  assign s_penable = r_s_penable;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_uvmt_apb_st_fanout_bridge.sv
// Directed bench for the APB fan-out bridge (NUM_SLV=4, TIMEOUT_CYCLES=16).
// A second instance with a 4-bit error counter exercises saturation quickly.
module tb_uvmt_apb_st_fanout_bridge;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  m_paddr;
  logic         m_psel, m_penable, m_pwrite;
  logic [31:0]  m_pwdata;
  logic         m_pready, m_pslverr;
  logic [31:0]  m_prdata;
  logic [31:0]  s_paddr;
  logic         s_pwrite;
  logic [31:0]  s_pwdata;
  logic [3:0]   s_psel;
  logic         s_penable;
  logic [3:0]   s_pready, s_pslverr;
  logic [127:0] s_prdata;
  logic [15:0]  err_count;

  logic         sat_m_pready, sat_m_pslverr, sat_s_pwrite, sat_s_penable;
  logic [31:0]  sat_m_prdata, sat_s_paddr, sat_s_pwdata;
  logic [3:0]   sat_s_psel;
  logic [3:0]   sat_err_count;

  int n_chk = 0;
  int n_fail = 0;

  // Slave model configuration
  logic [31:0] cfg_rdata [4];
  int          cfg_wait  [4];
  logic        cfg_err   [4];
  logic        cfg_hang  [4];
  logic [3:0]  force_rdy;
  int          acc_cnt = 0;

  // Transfer observations
  int          obs_lat;
  logic [3:0]  obs_psel_k1, obs_psel_k2, obs_psel_or, obs_psel_prev, obs_psel_resp;
  logic        obs_pen_k1, obs_pen_k2, obs_pwrite, obs_slverr, obs_pready_after;
  logic [31:0] obs_paddr, obs_pwdata, obs_rdata, obs_rdata_hold;

  uvmt_apb_st_fanout_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(4), .WIN_BITS(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .m_prdata(m_prdata), .s_paddr(s_paddr), .s_pwrite(s_pwrite), .s_pwdata(s_pwdata),
    .s_psel(s_psel), .s_penable(s_penable), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .s_prdata(s_prdata), .err_count(err_count)
  );

  uvmt_apb_st_fanout_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(4), .WIN_BITS(12), .TIMEOUT_CYCLES(16),
    .ERR_WIDTH(4)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pready(sat_m_pready), .m_pslverr(sat_m_pslverr),
    .m_prdata(sat_m_prdata), .s_paddr(sat_s_paddr), .s_pwrite(sat_s_pwrite), .s_pwdata(sat_s_pwdata),
    .s_psel(sat_s_psel), .s_penable(sat_s_penable), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .s_prdata(s_prdata), .err_count(sat_err_count)
  );

  always #5 clk = ~clk;

  // Count ACCESS cycles so each slave can insert its configured wait states.
  always @(posedge clk) begin
    if (s_penable) acc_cnt <= acc_cnt + 1;
    else           acc_cnt <= 0;
  end

  // Slave responders plus forced pready bits for ignore checks.
  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    s_prdata  = '0;
    for (int i = 0; i < 4; i++) begin
      s_pready[i]  = force_rdy[i] | (s_psel[i] & s_penable & ~cfg_hang[i] & (acc_cnt >= cfg_wait[i]));
      s_pslverr[i] = cfg_err[i];
      s_prdata[i*32 +: 32] = cfg_rdata[i];
    end
  end

  // One upstream transfer; records what the DUT shows in each cycle.
  task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
    obs_lat = -1;
    obs_psel_or = '0;
    obs_psel_prev = '0;
    obs_psel_resp = '0;
    m_paddr = addr; m_pwrite = wr; m_pwdata = wdata; m_psel = 1'b1; m_penable = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        m_penable = 1'b1;
        obs_psel_k1 = s_psel; obs_pen_k1 = s_penable;
        obs_paddr = s_paddr; obs_pwdata = s_pwdata; obs_pwrite = s_pwrite;
      end
      if (k == 2) begin
        obs_psel_k2 = s_psel; obs_pen_k2 = s_penable;
      end
      obs_psel_or = obs_psel_or | s_psel;
      if (m_pready) begin
        obs_lat = k; obs_rdata = m_prdata; obs_slverr = m_pslverr; obs_psel_resp = s_psel;
        break;
      end
      obs_psel_prev = s_psel;
    end
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge clk); #1;
    obs_pready_after = m_pready;
    obs_rdata_hold = m_prdata;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; m_paddr = '0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (m_pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b expected 0", m_pready); end
    n_chk++; if (m_pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b expected 0", m_pslverr); end
    n_chk++; if (m_prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", m_prdata); end
    n_chk++; if (s_psel !== 4'h0 || s_penable !== 1'b0) begin n_fail++; $display("FAIL reset_psel: got %b/%b expected 0000/0", s_psel, s_penable); end
    n_chk++; if (s_paddr !== 32'h0 || s_pwdata !== 32'h0 || s_pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_s_bus: got %h/%h/%b expected 0", s_paddr, s_pwdata, s_pwrite); end
    n_chk++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err_count: got %h expected 0", err_count); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_write();
    do_xfer(32'h0000_1004, 1'b1, 32'hDEAD_BEEF);
    n_chk++; if (obs_psel_k1 !== 4'b0010 || obs_pen_k1 !== 1'b0) begin n_fail++; $display("FAIL write_setup: got psel=%b pen=%b expected 0010/0", obs_psel_k1, obs_pen_k1); end
    n_chk++; if (obs_psel_k2 !== 4'b0010 || obs_pen_k2 !== 1'b1) begin n_fail++; $display("FAIL write_access: got psel=%b pen=%b expected 0010/1", obs_psel_k2, obs_pen_k2); end
    n_chk++; if (obs_paddr !== 32'h0000_1004 || obs_pwrite !== 1'b1) begin n_fail++; $display("FAIL write_paddr: got %h/%b expected 00001004/1", obs_paddr, obs_pwrite); end
    n_chk++; if (obs_pwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_pwdata: got %h expected deadbeef", obs_pwdata); end
    n_chk++; if (obs_lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d expected 3", obs_lat); end
    n_chk++; if (obs_slverr !== 1'b0 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL write_resp: got slverr=%b rdata=%h expected 0/0", obs_slverr, obs_rdata); end
    n_chk++; if (obs_pready_after !== 1'b0) begin n_fail++; $display("FAIL write_pready_pulse: got %b expected 0", obs_pready_after); end
    n_chk++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL write_err_count: got %0d expected 0", err_count); end
    $display("test_write: lat=%0d psel=%b paddr=%h", obs_lat, obs_psel_k1, obs_paddr);
  endtask

  task automatic test_decode_err();
    do_xfer(32'h0000_4000, 1'b0, 32'h0);
    n_chk++; if (obs_psel_or !== 4'h0) begin n_fail++; $display("FAIL dec_psel: got %b expected 0000", obs_psel_or); end
    n_chk++; if (obs_lat !== 1) begin n_fail++; $display("FAIL dec_latency: got %0d expected 1", obs_lat); end
    n_chk++; if (obs_slverr !== 1'b1 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL dec_resp: got slverr=%b rdata=%h expected 1/0", obs_slverr, obs_rdata); end
    n_chk++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL dec_err_count: got %0d expected 1", err_count); end
    $display("test_decode_err: lat=%0d slverr=%b err_count=%0d", obs_lat, obs_slverr, err_count);
  endtask

  task automatic test_read_wait();
    cfg_wait[3] = 2; cfg_rdata[3] = 32'h1234_5678;
    do_xfer(32'h0000_3010, 1'b0, 32'h0);
    n_chk++; if (obs_psel_k1 !== 4'b1000 || obs_pwrite !== 1'b0) begin n_fail++; $display("FAIL read_setup: got psel=%b pwrite=%b expected 1000/0", obs_psel_k1, obs_pwrite); end
    n_chk++; if (obs_lat !== 5) begin n_fail++; $display("FAIL read_latency: got %0d expected 5", obs_lat); end
    n_chk++; if (obs_rdata !== 32'h1234_5678 || obs_slverr !== 1'b0) begin n_fail++; $display("FAIL read_resp: got rdata=%h slverr=%b expected 12345678/0", obs_rdata, obs_slverr); end
    n_chk++; if (obs_rdata_hold !== 32'h1234_5678) begin n_fail++; $display("FAIL read_hold: got %h expected 12345678", obs_rdata_hold); end
    n_chk++; if (err_count !== 16'd1) begin n_fail++; $display("FAIL read_err_count: got %0d expected 1", err_count); end
    $display("test_read_wait: lat=%0d rdata=%h", obs_lat, obs_rdata);
  endtask

  task automatic test_timeout();
    logic seen;
    cfg_hang[2] = 1'b1; cfg_rdata[2] = 32'hCAFE_F00D;
    force_rdy = 4'b1001;
    do_xfer(32'h0000_2000, 1'b0, 32'h0);
    force_rdy = 4'b0000;
    n_chk++; if (obs_lat !== 18) begin n_fail++; $display("FAIL tmo_latency: got %0d expected 18", obs_lat); end
    n_chk++; if (obs_psel_prev !== 4'b0100 || obs_psel_resp !== 4'b0000) begin n_fail++; $display("FAIL tmo_psel: got %b->%b expected 0100->0000", obs_psel_prev, obs_psel_resp); end
    n_chk++; if (obs_slverr !== 1'b1 || obs_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_resp: got slverr=%b rdata=%h expected 1/0", obs_slverr, obs_rdata); end
    n_chk++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL tmo_err_count: got %0d expected 2", err_count); end
    seen = 1'b0;
    force_rdy = 4'b0100;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | m_pready;
    end
    force_rdy = 4'b0000;
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL tmo_late_pready: got pready=%b expected 0", seen); end
    n_chk++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL tmo_late_err_count: got %0d expected 2", err_count); end
    cfg_hang[2] = 1'b0;
    $display("test_timeout: lat=%0d slverr=%b err_count=%0d", obs_lat, obs_slverr, err_count);
  endtask

  task automatic test_slave_err();
    int pulses;
    cfg_err[0] = 1'b1; cfg_rdata[0] = 32'h0BAD_C0DE;
    do_xfer(32'h0000_0020, 1'b0, 32'h0);
    cfg_err[0] = 1'b0;
    n_chk++; if (obs_lat !== 3) begin n_fail++; $display("FAIL slverr_latency: got %0d expected 3", obs_lat); end
    n_chk++; if (obs_slverr !== 1'b1 || obs_rdata !== 32'h0BAD_C0DE) begin n_fail++; $display("FAIL slverr_resp: got slverr=%b rdata=%h expected 1/0badc0de", obs_slverr, obs_rdata); end
    n_chk++; if (err_count !== 16'd3 || sat_err_count !== 4'd3) begin n_fail++; $display("FAIL slverr_err_count: got %0d/%0d expected 3/3", err_count, sat_err_count); end
    // Burst of 40 back-to-back decode errors (setup held, one accepted every other edge)
    pulses = 0;
    m_paddr = 32'h0000_4000; m_pwrite = 1'b0; m_psel = 1'b1; m_penable = 1'b0;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clk); #1;
      if (m_pready) pulses++;
      if (e == 79) m_psel = 1'b0;
    end
    n_chk++; if (pulses !== 40) begin n_fail++; $display("FAIL burst_pulses: got %0d expected 40", pulses); end
    n_chk++; if (m_pslverr !== 1'b1) begin n_fail++; $display("FAIL burst_pslverr: got %b expected 1", m_pslverr); end
    n_chk++; if (err_count !== 16'd43) begin n_fail++; $display("FAIL burst_err_count: got %0d expected 43", err_count); end
    n_chk++; if (sat_err_count !== 4'hF) begin n_fail++; $display("FAIL burst_saturate: got %h expected f", sat_err_count); end
    $display("test_slave_err: pulses=%0d err_count=%0d sat=%h", pulses, err_count, sat_err_count);
  endtask

  task automatic test_reset_mid();
    cfg_wait[1] = 5;
    m_paddr = 32'h0000_1008; m_pwrite = 1'b1; m_pwdata = 32'h1111_2222; m_psel = 1'b1; m_penable = 1'b0;
    @(posedge clk); #1; m_penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++; if (s_psel !== 4'b0010 || s_penable !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_access: got %b/%b expected 0010/1", s_psel, s_penable); end
    reset_n = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (s_psel !== 4'h0 || s_penable !== 1'b0 || m_pready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got psel=%b pen=%b pready=%b expected 0", s_psel, s_penable, m_pready); end
    n_chk++; if (s_paddr !== 32'h0 || m_pslverr !== 1'b0 || m_prdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h/%b/%h expected 0", s_paddr, m_pslverr, m_prdata); end
    n_chk++; if (err_count !== 16'd0 || sat_err_count !== 4'd0) begin n_fail++; $display("FAIL rstmid_err_count: got %0d/%0d expected 0/0", err_count, sat_err_count); end
    reset_n = 1'b1; cfg_wait[1] = 0;
    @(posedge clk); #1;
    do_xfer(32'h0000_1008, 1'b1, 32'h55AA_55AA);
    n_chk++; if (obs_lat !== 3 || obs_psel_k1 !== 4'b0010) begin n_fail++; $display("FAIL rstmid_fresh: got lat=%0d psel=%b expected 3/0010", obs_lat, obs_psel_k1); end
    n_chk++; if (obs_pwdata !== 32'h55AA_55AA || obs_slverr !== 1'b0) begin n_fail++; $display("FAIL rstmid_fresh_data: got %h/%b expected 55aa55aa/0", obs_pwdata, obs_slverr); end
    $display("test_reset_mid: fresh lat=%0d err_count=%0d", obs_lat, err_count);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      cfg_rdata[i] = 32'hA5A5_0000 + 32'(i); cfg_wait[i] = 0; cfg_err[i] = 1'b0; cfg_hang[i] = 1'b0;
    end
    cfg_rdata[1] = 32'hAAAA_5555;
    force_rdy = 4'b0000;
    test_reset();
    test_write();
    test_decode_err();
    test_read_wait();
    test_timeout();
    test_slave_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
